// File: rtl/addsub_serial_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_serial_pipe_if
//  Brief    : Operand/result handshake bundle for the serial add/sub unit.
//             The master side issues operands and consumes results.
//  Revision : 1.0  initial release
// ============================================================================
interface addsub_serial_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovfl;
    logic             cout;
    logic             zero;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, ovfl, cout, zero
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, ovfl, cout, zero
    );
endinterface
`default_nettype wire

// File: rtl/addsub_serial_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_serial_pipe
//  Brief    : Signed add/subtract processing CHUNK bits per clock through a
//             registered carry chain, with wrap/saturate modes, overflow,
//             carry and zero flags, and valid/ready on both sides.
//             CHUNK must divide WIDTH exactly.
//  Revision : 1.0  initial release
// ============================================================================
module addsub_serial_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    addsub_serial_pipe_if.slave bus
);

    localparam int c_NCHUNK = WIDTH / CHUNK;
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [WIDTH-1:0]   c_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;        // b already inverted for subtract
    logic                 r_carry;
    logic                 r_sat;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic                 r_ovfl;
    logic                 r_cout;
    logic                 r_zero;

    logic [CHUNK-1:0]     w_a_chunk;
    logic [CHUNK-1:0]     w_b_chunk;
    logic [CHUNK:0]       w_chunk_sum;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_ovfl;
    logic [WIDTH-1:0]     w_final;

    // Current chunk addition, full sum with this chunk merged in, and the
    // overflow/saturation outcome used on the last chunk's edge.
    always_comb begin
        w_a_chunk   = r_a[r_idx*CHUNK +: CHUNK];
        w_b_chunk   = r_b[r_idx*CHUNK +: CHUNK];
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_sum       = r_result;
        w_sum[r_idx*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
        // Comparing against the inverted b (not a negated b) keeps A-MIN correct.
        w_ovfl      = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        w_final     = (r_sat && w_ovfl) ? (r_a[WIDTH-1] ? c_MIN : c_MAX) : w_sum;
    end

    // Control FSM with operand capture, chunk sequencing and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sat       <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovfl      <= 1'b0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.mode[0] ? ~bus.b : bus.b;
                        r_carry    <= bus.mode[0];
                        r_sat      <= bus.mode[1];
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_result <= w_sum;
                    r_carry  <= w_chunk_sum[CHUNK];
                    if (r_idx == c_LAST_IDX) begin
                        r_result    <= w_final;
                        r_ovfl      <= w_ovfl;
                        r_cout      <= w_chunk_sum[CHUNK];
                        r_zero      <= (w_final == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                S_DONE: begin
                    // No new accept on the output handshake edge.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.ovfl      = r_ovfl;
    assign bus.cout      = r_cout;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_serial_pipe
//  Brief    : Scoreboard bench for addsub_serial_pipe in four configurations
//             (8/4, 16/16, 16/8, 16/1): directed corner cases, a reset abort
//             and random operations against an integer reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addsub_serial_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic        ovfl;
        logic        cout;
        logic        zero;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  mode;
        bit          abort;
        exp_t        e;
    } op_t;

    localparam int LIM = 200;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Signed add/sub on plain integers, then saturate and wrap modulo 2^w.
    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic [1:0] mode);
        exp_t   e;
        longint m, ua, ub, sa, sb, r, mx, mn, wr;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        mx = m / 2 - 1;
        mn = -(m / 2);
        r  = mode[0] ? sa - sb : sa + sb;
        e.ovfl = (r > mx) || (r < mn);
        e.cout = mode[0] ? (ua >= ub) : (ua + ub >= m);
        if (mode[1] && e.ovfl) r = (r > mx) ? mx : mn;
        wr     = ((r % m) + m) % m;
        e.res  = 16'(wr);
        e.zero = (wr == 0);
        e.acc  = 0;
        return e;
    endfunction

    function automatic op_t mk(logic [15:0] a, logic [15:0] b, logic [1:0] m,
                               logic [15:0] r, logic ov, logic co, logic z);
        op_t o;
        o.a = a; o.b = b; o.mode = m; o.abort = 1'b0;
        o.e.res = r; o.e.ovfl = ov; o.e.cout = co; o.e.zero = z; o.e.acc = 0;
        return o;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W     = (g == 0) ? 8 : 16;
        localparam int C     = (g == 0) ? 4 : (g == 1) ? 16 : (g == 2) ? 8 : 1;
        localparam int NC    = W / C;
        localparam int NRAND = (g == 0) ? 300 : 1000;

        logic  rst_g;
        exp_t  q[$];
        op_t   ops[$];
        string tag;

        addsub_serial_pipe_if #(.WIDTH(W)) ifc ();

        addsub_serial_pipe #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk (clk),
            .rst (rst_g),
            .bus (ifc)
        );

        // Driver: builds the op list, issues it with valid held until ready.
        initial begin
            op_t         o;
            exp_t        e;
            int          t;
            logic [15:0] msk, mx, mn;
            tag = $sformatf("W%0d/C%0d", W, C);
            msk = 16'((32'd1 << W) - 1);
            mx  = msk >> 1;
            mn  = mx + 16'd1;
            ifc.in_valid = 1'b0;
            ifc.a = '0; ifc.b = '0; ifc.mode = 2'b00;
            rst_g = 1'b1;
            repeat (2) @(negedge clk);
            chk({tag, " rst_in_ready"},  32'(ifc.in_ready), 1);
            chk({tag, " rst_out_valid"}, 32'(ifc.out_valid), 0);
            chk({tag, " rst_result"},    32'(ifc.result), 0);
            chk({tag, " rst_flags"},     {29'd0, ifc.ovfl, ifc.cout, ifc.zero}, 0);
            @(posedge clk); #1 rst_g = 1'b0;

            ops.push_back(mk(mx,     16'd1, 2'b00, mn,    1'b1, 1'b0, 1'b0));
            ops.push_back(mk(mx,     16'd1, 2'b10, mx,    1'b1, 1'b0, 1'b0));
            ops.push_back(mk(16'd5,  16'd5, 2'b01, 16'd0, 1'b0, 1'b1, 1'b1));
            ops.push_back(mk(16'd0,  16'd1, 2'b01, msk,   1'b0, 1'b0, 1'b0));
            ops.push_back(mk(16'd0,  mn,    2'b01, mn,    1'b1, 1'b0, 1'b0));
            ops.push_back(mk(16'd0,  mn,    2'b11, mx,    1'b1, 1'b0, 1'b0));
            ops.push_back(mk(mn,     16'd1, 2'b11, mn,    1'b1, 1'b1, 1'b0));
            o = mk(16'h0033 & msk, 16'h0011 & msk, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0);
            o.abort = 1'b1;
            ops.push_back(o);
            for (int i = 0; i < NRAND; i++) begin
                o.a     = 16'($urandom) & msk;
                o.b     = 16'($urandom) & msk;
                o.mode  = 2'($urandom);
                o.abort = 1'b0;
                o.e     = model(W, o.a, o.b, o.mode);
                ops.push_back(o);
            end

            foreach (ops[i]) begin
                @(negedge clk);
                ifc.in_valid = 1'b1;
                ifc.a        = ops[i].a[W-1:0];
                ifc.b        = ops[i].b[W-1:0];
                ifc.mode     = ops[i].mode;
                t = 0;
                while (ifc.in_ready !== 1'b1 && t < LIM) begin
                    @(negedge clk);
                    t++;
                end
                chk({tag, " accept_timeout"}, 32'(t >= LIM), 0);
                if (t >= LIM) break;
                if (ops[i].abort) begin
                    @(posedge clk);
                    #1 ifc.in_valid = 1'b0;
                    rst_g = 1'b1;
                    #1;
                    chk({tag, " abort_in_ready"},  32'(ifc.in_ready), 1);
                    chk({tag, " abort_out_valid"}, 32'(ifc.out_valid), 0);
                    chk({tag, " abort_result"},    32'(ifc.result), 0);
                    chk({tag, " abort_flags"},     {29'd0, ifc.ovfl, ifc.cout, ifc.zero}, 0);
                    @(posedge clk);
                    #1 rst_g = 1'b0;
                end else begin
                    e     = ops[i].e;
                    e.acc = cyc + 1;
                    q.push_back(e);
                end
            end
            @(negedge clk);
            ifc.in_valid = 1'b0;
            t = 0;
            while (q.size() != 0 && t < LIM) begin
                @(negedge clk);
                t++;
            end
            chk({tag, " drain_timeout"}, 32'(q.size()), 0);
            n_done++;
        end

        // Monitor: checks each presented result against the scoreboard head,
        // applying random backpressure of 0..5 cycles.
        initial begin
            exp_t        e;
            int          stall;
            logic        prev;
            logic [15:0] r16;
            ifc.out_ready = 1'b0;
            prev  = 1'b0;
            stall = 0;
            forever begin
                @(negedge clk);
                if (ifc.out_valid === 1'b1) begin
                    chk({tag, " out_valid_expected"}, 32'(q.size() != 0), 1);
                    if (q.size() == 0) begin
                        ifc.out_ready = 1'b1;
                    end else begin
                        e = q[0];
                        if (!prev) begin
                            chk({tag, " latency"}, 32'(cyc - e.acc), NC);
                            stall = $urandom_range(0, 5);
                        end
                        r16 = '0;
                        r16[W-1:0] = ifc.result;
                        chk({tag, " result"},   32'(r16), 32'(e.res));
                        chk({tag, " ovfl"},     32'(ifc.ovfl), 32'(e.ovfl));
                        chk({tag, " cout"},     32'(ifc.cout), 32'(e.cout));
                        chk({tag, " zero"},     32'(ifc.zero), 32'(e.zero));
                        chk({tag, " in_ready_while_done"}, 32'(ifc.in_ready), 0);
                        if (stall == 0) begin
                            ifc.out_ready = 1'b1;
                            void'(q.pop_front());
                        end else begin
                            ifc.out_ready = 1'b0;
                            stall--;
                        end
                    end
                end else begin
                    ifc.out_ready = 1'($urandom_range(0, 1));
                end
                prev = ifc.out_valid;
            end
        end
    end

    // Wait for every configuration to finish, then report.
    initial begin
        int t;
        t = 0;
        while (n_done < 4 && t < 90000) begin
            @(negedge clk);
            t++;
        end
        chk("all_configs_done", 32'(n_done), 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
